// File: rtl/osf_mb_pkg.sv
// Shared widths, FSM state type and bit-scan helpers for the OSF event mailbox consumer.
package osf_mb_pkg;

    localparam int unsigned VEC_W = 20;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ID_W  = $clog2(VEC_W);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } stateT;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [ID_W-1:0] lowest_set(input logic [VEC_W-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic onehot_or_zero(input logic [VEC_W-1:0] vec);
        return (vec & (vec - VEC_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/osf_mb_event_dispatch_if.sv
// Mailbox write port and event-sink port of the OSF event dispatcher.
interface osf_mb_event_dispatch_if;
    import osf_mb_pkg::*;

    logic             mb_valid;
    logic [VEC_W-1:0] mb_vec;
    logic             mb_ready;
    logic             ev_valid;
    logic [ID_W-1:0]  ev_id;
    logic             ev_last;
    logic             ev_ready;
    logic             vec_done;
    logic [LVL_W-1:0] fifo_level;
    logic             busy;

    modport master (
        output mb_valid, mb_vec, ev_ready,
        input  mb_ready, ev_valid, ev_id, ev_last, vec_done, fifo_level, busy
    );

    modport slave (
        input  mb_valid, mb_vec, ev_ready,
        output mb_ready, ev_valid, ev_id, ev_last, vec_done, fifo_level, busy
    );

endinterface

// File: rtl/osf_mb_vec_fifo.sv
// DEPTH x VEC_W synchronous vector FIFO with occupancy output; caller guards push/pop.
module osf_mb_vec_fifo
    import osf_mb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [VEC_W-1:0] pushData,
    input  logic             pop,
    output logic [VEC_W-1:0] popData,
    output logic [LVL_W-1:0] level,
    output logic             empty
);

    logic [VEC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [LVL_W-1:0] count;

    // Pointers are PTR_W wide, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    assign popData = mem[rdPtr];
    assign level   = count;
    assign empty   = (count == '0);

endmodule

// File: rtl/osf_mb_event_dispatch.sv
// OSF mailbox consumer: buffers event vectors and dispatches their set bits lowest first.
module osf_mb_event_dispatch
    import osf_mb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    osf_mb_event_dispatch_if.slave bus
);

    stateT            state;
    stateT            stateNext;
    logic [VEC_W-1:0] pend;
    logic [VEC_W-1:0] pendNext;
    logic [ID_W-1:0]  evId;
    logic             evLast;
    logic             zeroDone;
    logic             zeroDoneNext;
    logic             vecDoneNow;
    logic             push;
    logic             pop;
    logic             fifoEmpty;
    logic [VEC_W-1:0] headVec;
    logic [LVL_W-1:0] level;

    assign bus.mb_ready = (level != LVL_W'(DEPTH));
    assign push         = bus.mb_valid & bus.mb_ready;

    osf_mb_vec_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pushData (bus.mb_vec),
        .pop      (pop),
        .popData  (headVec),
        .level    (level),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            evId     <= '0;
            evLast   <= 1'b0;
            zeroDone <= 1'b0;
        end else begin
            state    <= stateNext;
            pend     <= pendNext;
            evId     <= lowest_set(pendNext);
            evLast   <= onehot_or_zero(pendNext) && (pendNext != '0);
            zeroDone <= zeroDoneNext;
        end
    end

    // Zero vectors retire straight from IDLE; the last handshake retires a dispatched vector.
    always_comb begin
        stateNext    = state;
        pendNext     = pend;
        pop          = 1'b0;
        zeroDoneNext = 1'b0;
        vecDoneNow   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop      = 1'b1;
                    pendNext = headVec;
                    if (headVec != '0) begin
                        stateNext = DISPATCH;
                    end else begin
                        zeroDoneNext = 1'b1;
                    end
                end
            end
            DISPATCH: begin
                if (bus.ev_ready) begin
                    pendNext = pend & ~(VEC_W'(1) << evId);
                    if (evLast) begin
                        vecDoneNow = 1'b1;
                        stateNext  = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.ev_valid   = (state == DISPATCH);
    assign bus.ev_id      = evId;
    assign bus.ev_last    = evLast;
    assign bus.vec_done   = zeroDone | vecDoneNow;
    assign bus.fifo_level = level;
    assign bus.busy       = (level != '0) || (state == DISPATCH);

endmodule

// File: doc/osf_mb_event_dispatch.md
Name: osf_mb_event_dispatch

Overview:
- Consumer end of the OSF event mailbox. Accepts 20-bit event vectors that the mailbox writer posts and buffers them in a small FIFO.
- Decomposes each vector into individual event IDs, lowest bit first, and hands them one per handshake to the downstream event sink.
- Sits between the mailbox write port and the emulator-side event handler. Gives the writer back-pressure and pulses a per-vector completion flag.

Parameters:
- VEC_W, 20, event vector width (bits per mailbox word)
- DEPTH, 4, vector FIFO entries (power of two, >=2)
- ID_W, 5, event ID width, = clog2(VEC_W)

Ports:
- clk  in  1  block clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mb_valid  in  1  writer presents a vector
- mb_vec  in  VEC_W  event vector; bit i set = event i pending
- mb_ready  out  1  FIFO can accept; a vector is accepted when mb_valid & mb_ready
- ev_valid  out  1  event ID presented
- ev_id  out  ID_W  index of the event bit being dispatched
- ev_last  out  1  ev_id is the final set bit of the current vector
- ev_ready  in  1  sink accepts; handshake when ev_valid & ev_ready
- vec_done  out  1  one-cycle pulse: current vector fully retired
- fifo_level  out  clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  FIFO non-empty or FSM in DISPATCH

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied; pending register cleared; FSM to IDLE.
  - Outputs: mb_ready=1, ev_valid=0, ev_id=0, ev_last=0, vec_done=0, fifo_level=0, busy=0.
  - Reset mid-dispatch discards all buffered and partially dispatched vectors; no vec_done is emitted for them.
- FIFO:
  - mb_ready = (fifo_level != DEPTH), derived from registered state only.
  - Push on accept; pop only in IDLE.
  - Push and pop in the same cycle leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE and DISPATCH; pending register pend[VEC_W-1:0].
- IDLE:
  - If FIFO non-empty, pop the head into pend.
  - Head non-zero: go to DISPATCH next cycle.
  - Head zero: stay IDLE and pulse vec_done next cycle (zero vector retired with no event).
- DISPATCH:
  - ev_valid=1; ev_id = index of lowest set bit of pend; ev_last = (pend has exactly one bit set).
  - On handshake, clear that bit. If ev_last, pulse vec_done in the same cycle and go to IDLE.
  - Without ready, ev_id and ev_last hold stable and ev_valid stays high (no retraction).
- Latency:
  - Vector accepted in cycle T is written to the FIFO at end of T.
  - If the FIFO was empty and the FSM in IDLE, it is popped in T+1 and ev_valid rises in T+2.
  - Between consecutive vectors there is one IDLE bubble cycle.
- Throughput: one event per cycle while ev_ready=1.
- Ordering: vectors are retired in acceptance order; bits within a vector are dispatched ascending.
- Bits above VEC_W do not exist; no saturation or truncation rules apply.
- busy = (fifo_level!=0) | (state==DISPATCH).

Decomposition:
- Package osf_mb_pkg holds:
  - VEC_W, ID_W, DEPTH defaults
  - state enum {IDLE, DISPATCH}
  - function lowest_set(vec) returning ID_W index
  - function onehot_or_zero(vec)
- One sub-module: osf_mb_vec_fifo, the synchronous DEPTH x VEC_W FIFO with level output, clk/rst_n.
- The FSM and bit scan stay in the top module.

Test Plan:
- Single vector 0x00005 with ev_ready=1 -> ev_valid at T+2 with id=0, then id=2 with ev_last=1; vec_done pulses with the second handshake; busy returns to 0.
- Zero vector 0x00000 -> no ev_valid; vec_done pulses at T+2; fifo_level goes 1->0.
- Fill: 5 back-to-back vectors with ev_ready=0 -> the first is popped, the FIFO refills to 4, and mb_ready drops to 0. The 6th is held until ev_ready rises; order of IDs is preserved.
- Back-pressure: vector 0x80001, ev_ready toggling 0/1 each cycle -> id=0 held stable until accepted, then id=19 with ev_last=1; no duplicate or skipped IDs.
- Full vector 0xFFFFF -> 20 consecutive IDs 0..19, only id=19 has ev_last; exactly one vec_done.
- rst_n asserted while DISPATCH is mid-vector with 2 queued -> all outputs at reset values immediately; after release, no events and no vec_done from the discarded vectors.
